// File: rtl/regfile_fwd_sb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_fwd_sb_pkg : forwarding-bus field layout and source priority names
// Rev 1.0
// ---------------------------------------------------------------------------
package regfile_fwd_sb_pkg;

   // Forwarding bus priority order: lower index is the younger stage and wins.
   typedef enum logic [1:0] {
      SRC_EX  = 2'd0,
      SRC_MEM = 2'd1,
      SRC_WB  = 2'd2
   } fwd_src_e;

   // Per-bus layout, MSB first: {we, ready, waddr, data}
   function automatic int fwd_w(input int data_w, input int addr_w);
      return data_w + addr_w + 2;
   endfunction

   function automatic int we_bit(input int data_w, input int addr_w);
      return data_w + addr_w + 1;
   endfunction

   function automatic int rdy_bit(input int data_w, input int addr_w);
      return data_w + addr_w;
   endfunction

   function automatic int addr_lsb(input int data_w);
      return data_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_fwd_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_fwd_port : one read port, priority forward / bypass / array select
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_fwd_port
   import regfile_fwd_sb_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_FWD = 3
) (
   input  logic [ADDR_W-1:0]                          raddr_i,
   input  logic                                       rd_en_i,
   input  logic [NUM_FWD*(DATA_W+ADDR_W+2)-1:0]       fwd_bus_i,
   input  logic                                       we_i,
   input  logic [ADDR_W-1:0]                          waddr_i,
   input  logic [DATA_W-1:0]                          wdata_i,
   input  logic [DATA_W-1:0]                          arr_rdata_i,
   output logic [DATA_W-1:0]                          rdata_o,
   output logic                                       hazard_o
);

   localparam int FWD_W    = fwd_w(DATA_W, ADDR_W);
   localparam int WE_BIT   = we_bit(DATA_W, ADDR_W);
   localparam int RDY_BIT  = rdy_bit(DATA_W, ADDR_W);
   localparam int ADDR_LSB = addr_lsb(DATA_W);

   logic              hit;
   logic              hit_rdy;
   logic [DATA_W-1:0] hit_data;

   // Scan oldest to youngest so the lowest-indexed matching bus overwrites.
   always_comb begin
      hit      = 1'b0;
      hit_rdy  = 1'b1;
      hit_data = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_bus_i[k*FWD_W + WE_BIT] &&
             (fwd_bus_i[k*FWD_W + ADDR_LSB +: ADDR_W] == raddr_i)) begin
            hit      = 1'b1;
            hit_rdy  = fwd_bus_i[k*FWD_W + RDY_BIT];
            hit_data = fwd_bus_i[k*FWD_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rdata_o = arr_rdata_i;
      if (raddr_i == '0) begin
         rdata_o = '0;
      end else if (hit) begin
         rdata_o = hit_data;
      end else if (we_i && (waddr_i == raddr_i)) begin
         rdata_o = wdata_i;
      end
   end

   assign hazard_o = rd_en_i && (raddr_i != '0) && hit && !hit_rdy;

endmodule
`default_nettype wire

// File: rtl/regfile_fwd_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_fwd_sb : ID register file with forwarding, load-use stall, counter
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_fwd_sb
   import regfile_fwd_sb_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_RD  = 2,
   parameter int NUM_FWD = 3,
   parameter int CNT_W   = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_RD*ADDR_W-1:0]              raddr_i,
   input  logic [NUM_RD-1:0]                     rd_en_i,
   output logic [NUM_RD*DATA_W-1:0]              rdata_o,
   input  logic [NUM_FWD*(DATA_W+ADDR_W+2)-1:0]  fwd_bus_i,
   input  logic                                  we_i,
   input  logic [ADDR_W-1:0]                     waddr_i,
   input  logic [DATA_W-1:0]                     wdata_i,
   input  logic                                  cnt_clr_i,
   output logic                                  stall_req_o,
   output logic [CNT_W-1:0]                      stall_cnt_o
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [NUM_RD-1:0] hazard;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic [CNT_W-1:0]  stall_cnt_d;

   // Entry 0 is never written; the read path forces it to zero regardless.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_port
      logic [ADDR_W-1:0] port_addr;
      assign port_addr = raddr_i[i*ADDR_W +: ADDR_W];

      regfile_fwd_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .NUM_FWD (NUM_FWD)
      ) u_port (
         .raddr_i     (port_addr),
         .rd_en_i     (rd_en_i[i]),
         .fwd_bus_i   (fwd_bus_i),
         .we_i        (we_i),
         .waddr_i     (waddr_i),
         .wdata_i     (wdata_i),
         .arr_rdata_i (mem_q[port_addr]),
         .rdata_o     (rdata_o[i*DATA_W +: DATA_W]),
         .hazard_o    (hazard[i])
      );
   end

   assign stall_req_o = !rst && (|hazard);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (cnt_clr_i) begin
         stall_cnt_d = '0;
      end else if (stall_req_o && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_fwd_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_fwd_sb : directed and randomized checks against a spec-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_fwd_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;
   localparam int NF = 3;
   localparam int CW = 2;
   localparam int FW = DW + AW + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*AW-1:0]  raddr;
   logic [NR-1:0]     rd_en;
   logic [NR*DW-1:0]  rdata;
   logic [NF*FW-1:0]  fwd_bus;
   logic              we;
   logic [AW-1:0]     waddr;
   logic [DW-1:0]     wdata;
   logic              cnt_clr;
   logic              stall_req;
   logic [CW-1:0]     stall_cnt;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mmem [2**AW];
   int            mcnt;

   regfile_fwd_sb #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .NUM_RD  (NR),
      .NUM_FWD (NF),
      .CNT_W   (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .raddr_i     (raddr),
      .rd_en_i     (rd_en),
      .rdata_o     (rdata),
      .fwd_bus_i   (fwd_bus),
      .we_i        (we),
      .waddr_i     (waddr),
      .wdata_i     (wdata),
      .cnt_clr_i   (cnt_clr),
      .stall_req_o (stall_req),
      .stall_cnt_o (stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] port_data(input int p);
      return rdata[p*DW +: DW];
   endfunction

   task automatic set_bus(input int k, input logic bwe, input logic brdy,
                          input logic [AW-1:0] badr, input logic [DW-1:0] bdat);
      fwd_bus[k*FW +: FW] = {bwe, brdy, badr, bdat};
   endtask

   task automatic set_port(input int p, input logic [AW-1:0] a, input logic en);
      raddr[p*AW +: AW] = a;
      rd_en[p]          = en;
   endtask

   task automatic clear_inputs();
      raddr   = '0;
      rd_en   = '0;
      fwd_bus = '0;
      we      = 1'b0;
      waddr   = '0;
      wdata   = '0;
      cnt_clr = 1'b0;
   endtask

   // Reference read: forward buses in priority order, then write bypass, then array.
   function automatic void model_port(input logic [AW-1:0] a, input logic en,
                                      output logic [DW-1:0] d, output logic hz);
      logic          found;
      logic [FW-1:0] bus;
      found = 1'b0;
      hz    = 1'b0;
      d     = mmem[a];
      if (a == '0) begin
         d = '0;
      end else begin
         for (int k = 0; k < NF; k++) begin
            bus = fwd_bus[k*FW +: FW];
            if (!found && bus[FW-1] && (bus[DW +: AW] == a)) begin
               found = 1'b1;
               d     = bus[DW-1:0];
               hz    = en && !bus[FW-2];
            end
         end
         if (!found && we && (waddr == a)) d = wdata;
      end
   endfunction

   function automatic logic model_stall();
      logic [DW-1:0] d;
      logic          hz;
      logic          any;
      any = 1'b0;
      for (int p = 0; p < NR; p++) begin
         model_port(raddr[p*AW +: AW], rd_en[p], d, hz);
         any = any | hz;
      end
      return any && !rst;
   endfunction

   // Advance one clock, updating the model with the inputs present at the edge.
   task automatic step();
      logic s;
      s = model_stall();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 2**AW; i++) mmem[i] = '0;
         mcnt = 0;
      end else begin
         if (we && (waddr != '0)) mmem[waddr] = wdata;
         if (cnt_clr) mcnt = 0;
         else if (s && (mcnt != (2**CW) - 1)) mcnt = mcnt + 1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA_AAAA;
      set_bus(0, 1'b1, 1'b0, 5'd3, 32'h0);
      set_port(0, 5'd3, 1'b1);
      #1;
      checks++;
      if (stall_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall_forced: got %b expected 0", stall_req);
      end
      step();
      step();
      rst = 1'b0;
      clear_inputs();
      set_port(0, 5'd3, 1'b1);
      #1;
      checks++;
      if (port_data(0) !== 32'h0) begin
         errors++;
         $display("FAIL reset_reg3: got %h expected 00000000", port_data(0));
      end
      checks++;
      if (stall_req !== 1'b0 || stall_cnt !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: stall %b cnt %0d expected 0 0", stall_req, stall_cnt);
      end
      we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
      set_port(0, 5'd0, 1'b1);
      #1;
      checks++;
      if (port_data(0) !== 32'h0) begin
         errors++;
         $display("FAIL reg0_bypass: got %h expected 00000000", port_data(0));
      end
      step();
      we = 1'b0;
      #1;
      checks++;
      if (port_data(0) !== 32'h0) begin
         errors++;
         $display("FAIL reg0_read: got %h expected 00000000", port_data(0));
      end
   endtask

   task automatic test_write_bypass();
      clear_inputs();
      we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
      set_port(0, 5'd7, 1'b1);
      #1;
      checks++;
      if (port_data(0) !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_bypass: got %h expected deadbeef", port_data(0));
      end
      step();
      we = 1'b0; wdata = '0;
      #1;
      checks++;
      if (port_data(0) !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL array_read: got %h expected deadbeef", port_data(0));
      end
   endtask

   task automatic test_priority();
      logic [DW-1:0] exp_d [4];
      exp_d = '{32'h44, 32'h33, 32'h22, 32'h11};
      clear_inputs();
      we = 1'b1; waddr = 5'd5; wdata = 32'h11;
      step();
      we = 1'b0;
      set_port(0, 5'd5, 1'b1);
      set_bus(2, 1'b1, 1'b1, 5'd5, 32'h22);
      set_bus(1, 1'b1, 1'b1, 5'd5, 32'h33);
      set_bus(0, 1'b1, 1'b1, 5'd5, 32'h44);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (port_data(0) !== exp_d[i]) begin
            errors++;
            $display("FAIL priority_%0d: got %h expected %h", i, port_data(0), exp_d[i]);
         end
         if (i < NF) fwd_bus[i*FW + FW - 1] = 1'b0;
      end
   endtask

   task automatic test_load_use();
      clear_inputs();
      set_bus(0, 1'b1, 1'b0, 5'd9, 32'h99);
      set_port(1, 5'd9, 1'b1);
      #1;
      checks++;
      if (stall_req !== 1'b1) begin
         errors++;
         $display("FAIL load_use_stall: got %b expected 1", stall_req);
      end
      rd_en[1] = 1'b0;
      #1;
      checks++;
      if (stall_req !== 1'b0 || port_data(1) !== 32'h99) begin
         errors++;
         $display("FAIL load_use_rden0: stall %b data %h expected 0 00000099", stall_req, port_data(1));
      end
      rd_en[1] = 1'b1;
      set_bus(0, 1'b1, 1'b1, 5'd9, 32'h55);
      set_bus(1, 1'b1, 1'b0, 5'd9, 32'h66);
      #1;
      checks++;
      if (stall_req !== 1'b0 || port_data(1) !== 32'h55) begin
         errors++;
         $display("FAIL younger_masks: stall %b data %h expected 0 00000055", stall_req, port_data(1));
      end
   endtask

   task automatic test_counter();
      int exp_c [5];
      exp_c = '{1, 2, 3, 3, 3};
      clear_inputs();
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      set_bus(0, 1'b1, 1'b0, 5'd9, 32'h0);
      set_port(1, 5'd9, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (stall_cnt !== exp_c[i][CW-1:0]) begin
            errors++;
            $display("FAIL counter_%0d: got %0d expected %0d", i, stall_cnt, exp_c[i]);
         end
      end
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      checks++;
      if (stall_cnt !== 2'd0) begin
         errors++;
         $display("FAIL counter_clr_wins: got %0d expected 0", stall_cnt);
      end
   endtask

   task automatic test_multi_port();
      clear_inputs();
      set_bus(0, 1'b1, 1'b0, 5'd0, 32'hFFFF_0000);
      set_bus(1, 1'b1, 1'b1, 5'd4, 32'h0000_0444);
      set_bus(2, 1'b1, 1'b1, 5'd6, 32'h0000_0666);
      set_port(0, 5'd4, 1'b1);
      set_port(1, 5'd6, 1'b1);
      set_port(2, 5'd0, 1'b1);
      #1;
      checks++;
      if (port_data(2) !== 32'h0 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL multi_port2_zero: data %h stall %b expected 00000000 0", port_data(2), stall_req);
      end
      checks++;
      if (port_data(0) !== 32'h444 || port_data(1) !== 32'h666) begin
         errors++;
         $display("FAIL multi_port_indep: got %h %h expected 00000444 00000666", port_data(0), port_data(1));
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] ed;
      logic          eh;
      logic          es;
      for (int it = 0; it < 400; it++) begin
         rst     = ($urandom_range(0, 49) == 0);
         cnt_clr = ($urandom_range(0, 15) == 0);
         we      = 1'($urandom);
         waddr   = AW'($urandom_range(0, 7));
         wdata   = $urandom;
         for (int p = 0; p < NR; p++) set_port(p, AW'($urandom_range(0, 7)), 1'($urandom));
         for (int k = 0; k < NF; k++)
            set_bus(k, 1'($urandom), ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), $urandom);
         #1;
         for (int p = 0; p < NR; p++) begin
            model_port(raddr[p*AW +: AW], rd_en[p], ed, eh);
            checks++;
            if (port_data(p) !== ed) begin
               errors++;
               $display("FAIL rand_rdata it%0d port%0d: got %h expected %h", it, p, port_data(p), ed);
            end
         end
         es = model_stall();
         checks++;
         if (stall_req !== es) begin
            errors++;
            $display("FAIL rand_stall it%0d: got %b expected %b", it, stall_req, es);
         end
         checks++;
         if (stall_cnt !== mcnt[CW-1:0]) begin
            errors++;
            $display("FAIL rand_cnt it%0d: got %0d expected %0d", it, stall_cnt, mcnt);
         end
         step();
      end
      rst = 1'b0;
   endtask

   initial begin
      mcnt = 0;
      rst  = 1'b1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_write_bypass();
      test_priority();
      test_load_use();
      test_counter();
      test_multi_port();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_fwd_sb.md
Name: regfile_fwd_sb

Overview:
Parametrised successor to the ID-stage register file. Provides NUM_RD combinational read ports with priority forwarding from NUM_FWD pipeline result buses and write-port bypass. Adds load-use hazard detection via a per-bus "data ready" bit, a synchronous clear of the whole array, and a saturating stall-cycle counter. It sits in ID, feeding operand muxes, and drives the pipeline stall controller.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register index width; depth = 2**ADDR_W, index 0 hardwired to zero
NUM_RD, 2, number of read ports
NUM_FWD, 3, number of forwarding buses; index 0 = youngest stage (EX), highest priority
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
raddr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_en  in  NUM_RD  port i actually consumes its operand (gates hazard detection only)
rdata  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
fwd_bus  in  NUM_FWD*(DATA_W+ADDR_W+2)  per bus, MSB first: {we, ready, waddr, data}
we  in  1  architectural write enable (from WB)
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
cnt_clr  in  1  clears stall counter
stall_req  out  1  operand not yet available; hold ID and earlier
stall_cnt  out  CNT_W  cycles in which stall_req was 1, saturating

Behaviour:
- Storage: 2**ADDR_W x DATA_W registers. On the clock edge with rst=1, all entries become 0. Otherwise, if we=1 and waddr!=0, entry[waddr] <= wdata. Writes to index 0 are ignored.
- Read resolution per port i, combinational, zero latency, first match wins:
  1. raddr_i==0 -> 0.
  2. Lowest-indexed bus k with we_k=1 and waddr_k==raddr_i -> data_k.
  3. we=1, waddr==raddr_i -> wdata (write-port bypass).
  4. Otherwise entry[raddr_i].
- A bus with we_k=0 never matches, whatever its address.
- Hazard: port i is hazardous if rd_en_i=1, raddr_i!=0, and the winning bus from step 2 has ready=0. stall_req = OR over ports, purely combinational.
  - Older buses are not consulted when a younger bus matches, even if the older one is ready.
  - During a hazard, rdata_i still shows data_k; its value is meaningless.
- rd_en_i=0 suppresses the stall contribution only; rdata is still resolved.
- stall_req is forced to 0 while rst=1.
- stall_cnt, evaluated in this order:
  - rst or cnt_clr -> 0.
  - Else if stall_req=1 and not all-ones -> +1.
  - At all-ones it holds (saturates).
  - If cnt_clr and stall_req are both 1, the clear wins.
- Reset values: stall_cnt=0, all array entries 0. Hence rdata reads 0 for any address not forwarded. stall_req=0.
- Reset mid-operation: array contents and the counter are discarded in the reset cycle. A write presented in the same cycle as rst is dropped.
- Simultaneous write and read of the same address, no forward match: the new wdata is returned in the same cycle (step 3). The array holds it from the next cycle.
- No X propagation: every read path is fully defined for all inputs.

Decomposition:
- Shared package/header: bus field offsets, computed from DATA_W/ADDR_W (WE_BIT, RDY_BIT, ADDR_LSB, FWD_W=DATA_W+ADDR_W+2), plus the priority-order constant for source naming (EX=0, MEM=1, WB=2).
- One sub-module, regfile_fwd_port: single-port resolver that takes raddr, rd_en, all buses, the write port and the array read value, and returns rdata_i and hazard_i. Instantiate it NUM_RD times in a generate loop. The top holds the array, the OR-reduce and the counter.

Test Plan:
- Reset/zero:
  - Assert rst for one cycle with we=1, waddr=3, wdata=0xAAAA_AAAA -> reg3 reads 0 afterwards, stall_req=0, stall_cnt=0.
  - Write 0x1234 to reg0 -> raddr=0 reads 0.
- Write/bypass:
  - Cycle n: we=1, waddr=7, wdata=0xDEADBEEF, raddr0=7 -> rdata0=0xDEADBEEF in cycle n.
  - Cycle n+1, we=0 -> still 0xDEADBEEF from the array.
- Priority: reg5=0x11, bus2={1,1,5,0x22}, bus1={1,1,5,0x33}, bus0={1,1,5,0x44} -> rdata=0x44.
  - Drop bus0 we -> 0x33.
  - Drop bus1 we -> 0x22.
- Load-use:
  - bus0={1,0,9,x}, raddr1=9, rd_en1=1 -> stall_req=1. Same with rd_en1=0 -> stall_req=0.
  - bus0={1,1,9,0x55} with bus1={1,0,9,x} -> stall_req=0, rdata=0x55 (younger-wins masking).
- Counter: with CNT_W=2, hold stall_req=1 for 5 cycles -> stall_cnt 1,2,3,3,3. Pulse cnt_clr with stall_req=1 -> 0 next cycle.
- Multi-port: NUM_RD=3, port2 raddr=0 with a bus matching address 0 -> rdata2=0, no stall. Ports 0/1 resolve independently to different buses in the same cycle.
